load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: bus-wait cycles allowed before a bus error is declared.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_read  input  1  current instruction is a load.
REQ-005 mem_write  input  1  current instruction is a store.
REQ-006 funct3  input  3  access size/sign (inst[14:12]).
REQ-007 addr  input  32  effective byte address (datapath ALU result).
REQ-008 wdata  input  32  store data (datapath rs2 value).
REQ-009 rdata  output  32  formatted load result, fed to the datapath memory-data write-back input.
REQ-010 stall  output  1  high = datapath holds PC and suppresses register write.
REQ-011 lsu_err  output  1  sticky error flag.
REQ-012 bus_valid  output  1  bus request.
REQ-013 bus_we  output  1  1 = write, 0 = read.
REQ-014 bus_addr  output  32  word address, bits [1:0] always 0.
REQ-015 bus_wdata  output  32  lane-aligned store data.
REQ-016 bus_be  output  4  byte enables (bit n = byte lane n).
REQ-017 bus_ready  input  1  bus accepts/completes transfer this cycle.
REQ-018 bus_rdata  input  32  read word, valid when bus_ready=1 and bus_we=0.

Function
REQ-019 FSM states: IDLE, BUSY, DONE, ERR.
REQ-020 IDLE, no request: stall=0, bus_valid=0.
REQ-021 IDLE, exactly one of mem_read/mem_write, legal funct3, aligned: stall=1 combinationally; register bus_addr={addr[31:2],2'b00}, bus_we, bus_be, bus_wdata, funct3, addr[1:0]; next state BUSY.
REQ-022 Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW.
REQ-023 Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00; byte always aligned.
REQ-024 IDLE with misalignment, illegal funct3, or mem_read=mem_write=1: next state ERR, no bus request issued.
REQ-025 BUSY: bus_valid=1, stall=1, all bus outputs stable until bus_ready=1.
REQ-026 BUSY with bus_ready=1: load captures formatted bus_rdata into rdata; next state DONE.
REQ-027 DONE: stall=0, bus_valid=0 for exactly one cycle (instruction retires); next state IDLE.
REQ-028 Store lanes: SB be=1<<addr[1:0], wdata[7:0] replicated to all 4 bytes; SH be=addr[1]?1100:0011, wdata[15:0] replicated to both halves; SW be=1111, wdata unchanged.
REQ-029 Loads: select byte/halfword by registered addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-030 rdata holds its value except on load completion; stores never alter it.
REQ-031 Wait counter clears on BUSY entry, increments each BUSY cycle without bus_ready; reaching TIMEOUT -> ERR, bus_valid deasserted.
REQ-032 ERR: lsu_err=1, stall=1, bus_valid=0; exit only by reset.
REQ-033 Load latency: request in IDLE at cycle 0, bus_ready at cycle k>=1 -> rdata valid and stall=0 at cycle k+1.

Reset
REQ-034 rst=1 asynchronously forces: state IDLE, counter 0, rdata=0, lsu_err=0, bus_valid=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0; stall then follows REQ-020/021.
REQ-035 Reset during BUSY abandons the transfer; bus_valid drops without waiting for bus_ready.

Structure
REQ-036 Package lsu_pkg holds the state enum, funct3 load/store constants and default TIMEOUT.
REQ-037 One combinational sub-module lsu_align: store lane/byte-enable generation and load extraction/extension.

Verification
REQ-038 SW addr=0x100, wdata=0xDEADBEEF, bus_ready after 2 cycles -> bus_addr=0x100, be=1111, stall high 3 cycles, low in DONE.
REQ-039 SB addr=0x103, wdata=0x000000A5 -> bus_addr=0x100, be=1000, bus_wdata=0xA5A5A5A5.
REQ-040 LB addr=0x102, bus_rdata=0x12F45678 -> rdata=0xFFFFFFF4; LBU same -> 0x000000F4; LHU addr=0x102 -> 0x000012F4.
REQ-041 LW addr=0x102 -> ERR, lsu_err=1, stall=1, no bus_valid; then rst=1 -> lsu_err=0, IDLE.
REQ-042 LW with bus_ready held 0, TIMEOUT=4 -> ERR after 4 BUSY cycles, bus_valid=0.
REQ-043 rst asserted mid-BUSY -> bus_valid=0 immediately, rdata=0, next request proceeds normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_ERR
    } lsu_state_t;

    // funct3 encodings (inst[14:12]); bits [1:0] give the access size
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT = 255;

    // True when the funct3/offset pair is a legal, naturally aligned access
    function automatic logic access_legal(input logic       is_load,
                                          input logic [2:0] f3,
                                          input logic [1:0] offset);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~offset[0];
            F3_W:    ok = (offset == 2'b00);
            F3_BU:   ok = is_load;
            F3_HU:   ok = is_load & ~offset[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: word-addressed valid/ready memory bus between the LSU and memory.
interface load_store_unit_if;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and byte/halfword extraction with extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_result
);
    logic [31:0] ld_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_shifted = ld_word >> {ld_offset, 3'b000};
    assign ld_byte    = ld_shifted[7:0];
    assign ld_half    = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];

    // Replicate narrow store data across all lanes and enable only the addressed bytes
    always_comb begin
        st_be    = 4'b1111;
        st_lanes = st_data;
        case (st_size)
            2'b00: begin
                st_be    = 4'b0001 << st_offset;
                st_lanes = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_lanes = st_data;
            end
        endcase
    end

    // Pick the addressed byte/halfword and sign- or zero-extend it to 32 bits
    always_comb begin
        ld_result = ld_word;
        case (ld_funct3)
            F3_B:    ld_result = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_result = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_result = {24'h0, ld_byte};
            F3_HU:   ld_result = {16'h0, ld_half};
            default: ld_result = ld_word;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: runs one load or store per instruction over the memory bus, stalling the
// datapath until it retires; misaligned/illegal accesses and bus timeouts latch a sticky error.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              lsu_err,
    load_store_unit_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_t    state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    funct3_q;
    logic [1:0]    offset_q;
    logic          req_any;
    logic          is_load;
    logic          is_store;
    logic          req_ok;
    logic [3:0]    st_be;
    logic [31:0]   st_lanes;
    logic [31:0]   ld_result;

    assign req_any  = mem_read | mem_write;
    assign is_load  = mem_read & ~mem_write;
    assign is_store = mem_write & ~mem_read;
    assign req_ok   = (is_load | is_store) && access_legal(is_load, funct3, addr[1:0]);

    lsu_align u_align (
        .st_size   (funct3[1:0]),
        .st_offset (addr[1:0]),
        .st_data   (wdata),
        .st_be     (st_be),
        .st_lanes  (st_lanes),
        .ld_funct3 (funct3_q),
        .ld_offset (offset_q),
        .ld_word   (bus.bus_rdata),
        .ld_result (ld_result)
    );

    // Hold the datapath from the request cycle until DONE; a faulted unit stalls forever
    always_comb begin
        stall = 1'b0;
        case (state)
            ST_IDLE:         stall = req_any;
            ST_BUSY, ST_ERR: stall = 1'b1;
            default:         stall = 1'b0;
        endcase
    end

    // Request capture, bus handshake, timeout watchdog and load write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
            rdata         <= 32'h0;
            lsu_err       <= 1'b0;
            bus.bus_valid <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        if (req_ok) begin
                            state         <= ST_BUSY;
                            wait_cnt      <= '0;
                            funct3_q      <= funct3;
                            offset_q      <= addr[1:0];
                            bus.bus_valid <= 1'b1;
                            bus.bus_we    <= is_store;
                            bus.bus_addr  <= {addr[31:2], 2'b00};
                            bus.bus_be    <= st_be;
                            bus.bus_wdata <= st_lanes;
                        end else begin
                            state   <= ST_ERR;
                            lsu_err <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.bus_ready) begin
                        state         <= ST_DONE;
                        bus.bus_valid <= 1'b0;
                        if (!bus.bus_we) begin
                            rdata <= ld_result;
                        end
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state         <= ST_ERR;
                        lsu_err       <= 1'b1;
                        bus.bus_valid <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors with a queue-based scoreboard for load_store_unit.
module tb_load_store_unit;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        lsu_err;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        rdata_pending = 1'b0;
    logic [31:0] rdata_exp = 32'h0;

    load_store_unit_if bus_if();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .lsu_err   (lsu_err),
        .bus       (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each completed bus transfer and the following DONE-cycle result
    always @(negedge clk) begin
        exp_t e;
        if (rdata_pending) begin
            checkOutput("done rdata", rdata, rdata_exp);
            checkOutput("done bus_valid", 32'(bus_if.bus_valid), 32'h0);
            rdata_pending = 1'b0;
        end
        if (bus_if.bus_valid && bus_if.bus_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected transfer", 32'(bus_if.bus_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("bus_we", 32'(bus_if.bus_we), 32'(e.we));
                checkOutput("bus_addr", bus_if.bus_addr, e.addr);
                checkOutput("bus_be", 32'(bus_if.bus_be), 32'(e.be));
                if (e.we) begin
                    checkOutput("bus_wdata", bus_if.bus_wdata, e.wdata);
                end
                rdata_exp     = e.rdata;
                rdata_pending = 1'b1;
            end
        end
    end

    // Issue one access; bus_ready is raised in the k-th BUSY cycle
    task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rword, input int k,
                                 input logic [31:0] e_addr, input logic [3:0] e_be,
                                 input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        exp_t e;
        int   stall_cycles;
        e.we = wr; e.addr = e_addr; e.be = e_be; e.wdata = e_wdata; e.rdata = e_rdata;
        exp_q.push_back(e);
        stall_cycles = 0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        bus_if.bus_rdata = rword;
        bus_if.bus_ready = 1'b0;
        for (int c = 0; c <= k; c++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            @(posedge clk); #1;
            bus_if.bus_ready = (c == k - 1);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        checkOutput({name, " stall in done"}, 32'(stall), 32'h0);
        checkOutput({name, " stall cycles"}, 32'(stall_cycles), 32'(k + 1));
    endtask

    // Faulting request: no bus activity, sticky error, cleared only by reset
    task automatic errCase(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput({name, " bus_valid"}, 32'(bus_if.bus_valid), 32'h0);
        end
        checkOutput({name, " lsu_err"}, 32'(lsu_err), 32'h1);
        checkOutput({name, " stall"}, 32'(stall), 32'h1);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; rst = 1'b1;
        #1;
        checkOutput({name, " lsu_err after rst"}, 32'(lsu_err), 32'h0);
        checkOutput({name, " stall after rst"}, 32'(stall), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int valid_cycles;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0;
        bus_if.bus_ready = 1'b0; bus_if.bus_rdata = 32'h0;
        #3;
        checkOutput("reset bus_valid", 32'(bus_if.bus_valid), 32'h0);
        checkOutput("reset bus_we", 32'(bus_if.bus_we), 32'h0);
        checkOutput("reset bus_addr", bus_if.bus_addr, 32'h0);
        checkOutput("reset bus_be", 32'(bus_if.bus_be), 32'h0);
        checkOutput("reset bus_wdata", bus_if.bus_wdata, 32'h0);
        checkOutput("reset rdata", rdata, 32'h0);
        checkOutput("reset lsu_err", 32'(lsu_err), 32'h0);
        checkOutput("reset stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus("SW", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2,
                      32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
        applyStimulus("SB", 1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1,
                      32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0);
        applyStimulus("LB", 1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h12F45678, 1,
                      32'h100, 4'b0100, 32'h0, 32'hFFFFFFF4);
        applyStimulus("LBU", 1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h12F45678, 3,
                      32'h100, 4'b0100, 32'h0, 32'h000000F4);
        applyStimulus("LHU", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h12F45678, 1,
                      32'h100, 4'b1100, 32'h0, 32'h000012F4);
        applyStimulus("LH", 1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h00008001, 2,
                      32'h100, 4'b0011, 32'h0, 32'hFFFF8001);
        applyStimulus("LW", 1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 1,
                      32'h104, 4'b1111, 32'h0, 32'hCAFEF00D);
        applyStimulus("SH", 1'b0, 1'b1, 3'b001, 32'h106, 32'h1234BEEF, 32'h0, 1,
                      32'h104, 4'b1100, 32'hBEEFBEEF, 32'hCAFEF00D);
        applyStimulus("LW slow", 1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h0BADC0DE, 4,
                      32'h108, 4'b1111, 32'h0, 32'h0BADC0DE);

        errCase("LW misaligned", 1'b1, 1'b0, 3'b010, 32'h102);
        errCase("read and write", 1'b1, 1'b1, 3'b010, 32'h100);
        errCase("SBU illegal", 1'b0, 1'b1, 3'b100, 32'h100);

        // Bus never answers: four BUSY cycles, then ERR with bus_valid low
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200; bus_if.bus_ready = 1'b0;
        valid_cycles = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus_if.bus_valid) valid_cycles++;
        end
        checkOutput("timeout busy cycles", 32'(valid_cycles), 32'd4);
        checkOutput("timeout bus_valid", 32'(bus_if.bus_valid), 32'h0);
        checkOutput("timeout lsu_err", 32'(lsu_err), 32'h1);
        @(posedge clk); #1;
        mem_read = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus("LW pre", 1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h55AA1234, 1,
                      32'h10C, 4'b1111, 32'h0, 32'h55AA1234);

        // Reset in the middle of a BUSY transfer
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; bus_if.bus_rdata = 32'h99999999;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid-busy bus_valid", 32'(bus_if.bus_valid), 32'h1);
        #1;
        rst = 1'b1; mem_read = 1'b0;
        #1;
        checkOutput("mid-busy rst bus_valid", 32'(bus_if.bus_valid), 32'h0);
        checkOutput("mid-busy rst rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus("SW post", 1'b0, 1'b1, 3'b010, 32'h110, 32'h01020304, 32'h0, 1,
                      32'h110, 4'b1111, 32'h01020304, 32'h0);
        applyStimulus("LB post", 1'b1, 1'b0, 3'b000, 32'h111, 32'h0, 32'h00007F00, 2,
                      32'h110, 4'b0010, 32'h0, 32'h0000007F);

        @(negedge clk);
        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
